// File: rtl/div_unit_cached.sv
// Iterative radix-2 restoring divider with a small round-robin result history.
// Fast paths: divide-by-zero, signed overflow, zero dividend and history hits.
module div_unit_cached #(
   parameter int W     = 32,
   parameter int DEPTH = 4
) (
   input  logic         clk,
   input  logic         rstn,
   input  logic         flush,
   input  logic         in_valid,
   output logic         in_ready,
   input  logic         in_sign,
   input  logic [W-1:0] op1,
   input  logic [W-1:0] op2,
   output logic         out_valid,
   input  logic         out_ready,
   output logic [W-1:0] quo,
   output logic [W-1:0] rem,
   output logic         out_hit
);

   localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int CW = $clog2(W + 1);

   typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

   state_t         state;
   logic [W-1:0]   a_lat;
   logic [W-1:0]   b_lat;
   logic           s_lat;
   logic           neg_q;
   logic           neg_r;
   logic [W-1:0]   b_mag;
   logic [W-1:0]   q_acc;
   logic [W-1:0]   r_acc;
   logic [CW-1:0]  cnt;

   logic           h_vld [DEPTH];
   logic [W-1:0]   h_op1 [DEPTH];
   logic [W-1:0]   h_op2 [DEPTH];
   logic           h_sgn [DEPTH];
   logic [W-1:0]   h_quo [DEPTH];
   logic [W-1:0]   h_rem [DEPTH];
   logic [PW-1:0]  wr_ptr;

   logic [W-1:0]   smin;
   logic [W-1:0]   a_mag_in;
   logic [W-1:0]   b_mag_in;
   logic           hit;
   logic [W-1:0]   hit_quo;
   logic [W-1:0]   hit_rem;
   logic           fast;
   logic           f_hit;
   logic [W-1:0]   f_quo;
   logic [W-1:0]   f_rem;

   logic [W:0]     sh;
   logic [W:0]     df;
   logic [W-1:0]   q_nx;
   logic [W-1:0]   r_nx;
   logic [W-1:0]   q_fix;
   logic [W-1:0]   r_fix;
   logic           last;
   logic           hist_we;

   assign smin     = {1'b1, {(W-1){1'b0}}};
   assign a_mag_in = (in_sign && op1[W-1]) ? -op1 : op1;
   assign b_mag_in = (in_sign && op2[W-1]) ? -op2 : op2;

   // Lowest matching index wins: scan downward so it is assigned last.
   always_comb begin
      hit     = 1'b0;
      hit_quo = '0;
      hit_rem = '0;
      for (int i = DEPTH - 1; i >= 0; i--) begin
         if (h_vld[i] && h_op1[i] == op1 &&
             h_op2[i] == op2 && h_sgn[i] == in_sign) begin
            hit     = 1'b1;
            hit_quo = h_quo[i];
            hit_rem = h_rem[i];
         end
      end
   end

   always_comb begin
      fast  = 1'b1;
      f_hit = 1'b0;
      f_quo = '0;
      f_rem = '0;
      if (op2 == '0) begin
         f_quo = '1;
         f_rem = op1;
      end else if (in_sign && op1 == smin && op2 == '1) begin
         f_quo = op1;
      end else if (op1 == '0) begin
         f_quo = '0;
      end else if (hit) begin
         f_hit = 1'b1;
         f_quo = hit_quo;
         f_rem = hit_rem;
      end else begin
         fast = 1'b0;
      end
   end

   // One restoring step: shift in the next dividend bit, try to subtract.
   always_comb begin
      sh = {r_acc, q_acc[W-1]};
      df = sh - {1'b0, b_mag};
      if (df[W]) begin
         r_nx = sh[W-1:0];
         q_nx = {q_acc[W-2:0], 1'b0};
      end else begin
         r_nx = df[W-1:0];
         q_nx = {q_acc[W-2:0], 1'b1};
      end
   end

   assign q_fix   = neg_q ? -q_nx : q_nx;
   assign r_fix   = neg_r ? -r_nx : r_nx;
   assign last    = (state == CALC) && (cnt == CW'(1));
   assign hist_we = last && !flush;

   always_ff @(posedge clk) begin
      if (!rstn) begin
         state     <= IDLE;
         in_ready  <= 1'b1;
         out_valid <= 1'b0;
         out_hit   <= 1'b0;
         quo       <= '0;
         rem       <= '0;
         a_lat     <= '0;
         b_lat     <= '0;
         s_lat     <= 1'b0;
         neg_q     <= 1'b0;
         neg_r     <= 1'b0;
         b_mag     <= '0;
         q_acc     <= '0;
         r_acc     <= '0;
         cnt       <= '0;
      end else if (flush) begin
         state     <= IDLE;
         in_ready  <= 1'b1;
         out_valid <= 1'b0;
         out_hit   <= 1'b0;
      end else begin
         unique case (state)
            IDLE: begin
               if (in_valid && in_ready) begin
                  a_lat    <= op1;
                  b_lat    <= op2;
                  s_lat    <= in_sign;
                  neg_q    <= in_sign & (op1[W-1] ^ op2[W-1]);
                  neg_r    <= in_sign & op1[W-1];
                  in_ready <= 1'b0;
                  if (fast) begin
                     state     <= DONE;
                     out_valid <= 1'b1;
                     quo       <= f_quo;
                     rem       <= f_rem;
                     out_hit   <= f_hit;
                  end else begin
                     state <= CALC;
                     cnt   <= CW'(W);
                     q_acc <= a_mag_in;
                     r_acc <= '0;
                     b_mag <= b_mag_in;
                  end
               end
            end
            CALC: begin
               q_acc <= q_nx;
               r_acc <= r_nx;
               cnt   <= cnt - CW'(1);
               if (last) begin
                  state     <= DONE;
                  out_valid <= 1'b1;
                  quo       <= q_fix;
                  rem       <= r_fix;
                  out_hit   <= 1'b0;
               end
            end
            DONE: begin
               if (out_ready) begin
                  state     <= IDLE;
                  out_valid <= 1'b0;
                  in_ready  <= 1'b1;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (!rstn) begin
         for (int i = 0; i < DEPTH; i++) h_vld[i] <= 1'b0;
         wr_ptr <= '0;
      end else if (hist_we) begin
         h_vld[wr_ptr] <= 1'b1;
         wr_ptr <= (wr_ptr == PW'(DEPTH - 1)) ? '0 : wr_ptr + PW'(1);
      end
   end

   always_ff @(posedge clk) begin
      if (hist_we) begin
         h_op1[wr_ptr] <= a_lat;
         h_op2[wr_ptr] <= b_lat;
         h_sgn[wr_ptr] <= s_lat;
         h_quo[wr_ptr] <= q_fix;
         h_rem[wr_ptr] <= r_fix;
      end
   end

endmodule
